multicycle_control: RTL and testbench

//  Moore FSM sequencing the multi-cycle MIPS datapath (shared memory, IR, A/B/ALUOut/MDR regs).

---
 rtl/mips_ctrl_pkg.sv | 65 ++++++
 rtl/multicycle_out_decode.sv | 86 ++++++++
 rtl/multicycle_control.sv | 105 ++++++++++
 tb/tb_multicycle_control.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcodes, multi-cycle FSM state encodings and
// datapath select codes, used by both the single-cycle decoder and the multi-cycle FSM.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_I_EXEC   = 4'd8,
        S_I_WB     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
        logic       illegal_op;
    } ctrl_t;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_BNE) || (op == OP_LW) ||
               (op == OP_SW) || (op == OP_ADDI) || (op == OP_LUI) || (op == OP_J);
    endfunction

endpackage

// File: rtl/multicycle_out_decode.sv
// Moore output decode for the multi-cycle FSM: state (+ latched opcode, zero flag
// and memory-ready qualifier) to datapath enables and mux selects.
module multicycle_out_decode
    import mips_ctrl_pkg::*;
(
    input  state_e      state_i,
    input  logic [5:0]  op_q_i,
    input  logic [5:0]  opcode_i,
    input  logic        zero_i,
    input  logic        mem_ok_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = mem_ok_i;
                ctrl_o.pc_write  = mem_ok_i;
                ctrl_o.alu_src_b = SRCB_FOUR;
                ctrl_o.alu_op    = ALUOP_ADD;
                ctrl_o.pc_source = PCSRC_ALU;
            end
            S_DECODE: begin
                // op_q is not loaded yet, so the illegal check looks at the live IR field
                ctrl_o.alu_src_b  = SRCB_IMM_SH;
                ctrl_o.alu_op     = ALUOP_ADD;
                ctrl_o.illegal_op = !is_legal_op(opcode_i);
            end
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = ALUOP_ADD;
            end
            S_MEM_RD: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WR: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.i_or_d     = 1'b1;
                ctrl_o.instr_done = mem_ok_i;
            end
            S_R_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_B;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_I_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
                ctrl_o.alu_op    = (op_q_i == OP_LUI) ? ALUOP_LUI : ALUOP_ADD;
            end
            S_I_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a  = 1'b1;
                ctrl_o.alu_src_b  = SRCB_B;
                ctrl_o.alu_op     = ALUOP_SUB;
                ctrl_o.pc_source  = PCSRC_ALUOUT;
                ctrl_o.pc_write   = (op_q_i == OP_BEQ) ? zero_i : !zero_i;
                ctrl_o.instr_done = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: state register, latched opcode, next-state logic,
// retired-instruction counter and reset gating of all datapath controls.
module multicycle_control
    import mips_ctrl_pkg::*;
#(
    parameter int MEM_HANDSHAKE = 1,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired_cnt
);

    state_e           state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_ok;
    ctrl_t            ctrl, ctrl_g;

    assign mem_ok = (MEM_HANDSHAKE == 0) || mem_ready;

    multicycle_out_decode u_out_decode (
        .state_i  (state_q),
        .op_q_i   (op_q),
        .opcode_i (opcode),
        .zero_i   (zero),
        .mem_ok_i (mem_ok),
        .ctrl_o   (ctrl)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        cnt_d   = cnt_q + CNT_W'(ctrl.instr_done);
        case (state_q)
            S_FETCH:    state_d = mem_ok ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RTYPE:         state_d = S_R_EXEC;
                    OP_ADDI, OP_LUI:  state_d = S_I_EXEC;
                    OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = mem_ok ? S_MEM_WB : S_MEM_RD;
            S_MEM_WR:   state_d = mem_ok ? S_FETCH : S_MEM_WR;
            S_R_EXEC:   state_d = S_R_WB;
            S_I_EXEC:   state_d = S_I_WB;
            default:    state_d = S_FETCH;
        endcase
    end

    // Reset must kill every write strobe in the same cycle it is asserted
    assign ctrl_g      = rst_n ? ctrl : '0;

    assign pc_write    = ctrl_g.pc_write;
    assign i_or_d      = ctrl_g.i_or_d;
    assign mem_read    = ctrl_g.mem_read;
    assign mem_write   = ctrl_g.mem_write;
    assign ir_write    = ctrl_g.ir_write;
    assign mem_to_reg  = ctrl_g.mem_to_reg;
    assign reg_dst     = ctrl_g.reg_dst;
    assign reg_write   = ctrl_g.reg_write;
    assign alu_src_a   = ctrl_g.alu_src_a;
    assign alu_src_b   = ctrl_g.alu_src_b;
    assign alu_op      = ctrl_g.alu_op;
    assign pc_source   = ctrl_g.pc_source;
    assign instr_done  = ctrl_g.instr_done;
    assign illegal_op  = ctrl_g.illegal_op;
    assign retired_cnt = cnt_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed and random instructions against a
// per-instruction phase-list model with a latency table and a modular retire count.
module tb_multicycle_control;

    localparam int CNT_W = 4;

    localparam logic [5:0] T_R    = 6'b000000;
    localparam logic [5:0] T_BEQ  = 6'b000100;
    localparam logic [5:0] T_BNE  = 6'b000101;
    localparam logic [5:0] T_LW   = 6'b100011;
    localparam logic [5:0] T_SW   = 6'b101011;
    localparam logic [5:0] T_ADDI = 6'b001000;
    localparam logic [5:0] T_LUI  = 6'b001111;
    localparam logic [5:0] T_J    = 6'b000010;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [5:0]       opcode = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg;
    logic             reg_dst, reg_write, alu_src_a, instr_done, illegal_op;
    logic [1:0]       alu_src_b, alu_op, pc_source;
    logic [CNT_W-1:0] retired_cnt;

    typedef struct packed {
        logic       pcw, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        logic       done, ill;
    } ov_t;

    typedef enum {P_F, P_D, P_A, P_RD, P_MWB, P_WR, P_RX, P_RWB, P_IX, P_IWB, P_BR, P_J} ph_t;

    ov_t obs;
    assign obs = {pc_write, i_or_d, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                  reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, illegal_op};

    int checks = 0;
    int failures = 0;
    int model_cnt = 0;

    multicycle_control #(.MEM_HANDSHAKE(1), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write),
        .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done),
        .illegal_op(illegal_op), .retired_cnt(retired_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    function automatic bit legal(input logic [5:0] op);
        return op inside {T_R, T_BEQ, T_BNE, T_LW, T_SW, T_ADDI, T_LUI, T_J};
    endfunction

    function automatic int latency(input logic [5:0] op);
        case (op)
            T_J, T_BEQ, T_BNE:  return 3;
            T_R, T_ADDI, T_LUI: return 4;
            T_SW:               return 4;
            T_LW:               return 5;
            default:            return 2;
        endcase
    endfunction

    // Expected control word for one phase of an instruction, straight from the output table
    function automatic ov_t expv(input ph_t p, input logic [5:0] op, input logic z, input logic rdy);
        ov_t e = '0;
        case (p)
            P_F:   begin e.mrd = 1; e.irw = rdy; e.pcw = rdy; e.asb = 2'b01; e.aop = 2'b10; end
            P_D:   begin e.asb = 2'b11; e.aop = 2'b10; e.ill = !legal(op); end
            P_A:   begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b10; end
            P_RD:  begin e.mrd = 1; e.iord = 1; end
            P_MWB: begin e.rw = 1; e.m2r = 1; e.done = 1; end
            P_WR:  begin e.mwr = 1; e.iord = 1; e.done = rdy; end
            P_RX:  begin e.asa = 1; e.asb = 2'b00; e.aop = 2'b00; end
            P_RWB: begin e.rw = 1; e.rdst = 1; e.done = 1; end
            P_IX:  begin e.asa = 1; e.asb = 2'b10; e.aop = (op == T_LUI) ? 2'b11 : 2'b10; end
            P_IWB: begin e.rw = 1; e.done = 1; end
            P_BR:  begin e.asa = 1; e.aop = 2'b01; e.psrc = 2'b01; e.done = 1;
                         e.pcw = (op == T_BEQ) ? z : !z; end
            P_J:   begin e.pcw = 1; e.psrc = 2'b10; e.done = 1; end
            default: e = '0;
        endcase
        return e;
    endfunction

    // sf/sm: cycles mem_ready is held low in FETCH / in the data-memory phase.
    // abort_at: phase index at which reset is asserted (-1 = run to completion).
    task automatic run_instr(input logic [5:0] op, input logic z, input int sf, input int sm,
                             input int abort_at);
        ph_t ph[$];
        int  k = 0, cyc = 0, stl = 0, here = 0;
        bit  w, rdy;
        ov_t e;
        ph.push_back(P_F);
        ph.push_back(P_D);
        case (op)
            T_LW:         begin ph.push_back(P_A); ph.push_back(P_RD); ph.push_back(P_MWB); end
            T_SW:         begin ph.push_back(P_A); ph.push_back(P_WR); end
            T_R:          begin ph.push_back(P_RX); ph.push_back(P_RWB); end
            T_ADDI, T_LUI: begin ph.push_back(P_IX); ph.push_back(P_IWB); end
            T_BEQ, T_BNE: ph.push_back(P_BR);
            T_J:          ph.push_back(P_J);
            default:      ;
        endcase
        while (k < ph.size() && cyc < 64) begin
            w   = ph[k] inside {P_F, P_RD, P_WR};
            rdy = !(w && here < ((ph[k] == P_F) ? sf : sm));
            mem_ready = w ? rdy : 1'($urandom);
            opcode    = (k <= 1) ? op : 6'($urandom);
            zero      = (ph[k] == P_BR) ? z : 1'($urandom);
            if (k == abort_at) begin
                rst_n = 1'b0;
                @(negedge clk);
                chk("abort_outputs", 32'(obs), 32'h0);
                @(posedge clk); #1;
                rst_n = 1'b1;
                model_cnt = 0;
                chk("abort_cnt", 32'(retired_cnt), 32'h0);
                return;
            end
            e = expv(ph[k], op, z, rdy);
            @(negedge clk);
            chk($sformatf("op%02h_cyc%0d_ph%0d", op, cyc, k), 32'(obs), 32'(e));
            @(posedge clk); #1;
            cyc++;
            if (rdy) begin k++; here = 0; end
            else begin here++; stl++; end
        end
        chk($sformatf("latency_op%02h", op), 32'(cyc), 32'(latency(op) + stl));
        model_cnt = (model_cnt + (legal(op) ? 1 : 0)) % (1 << CNT_W);
        chk($sformatf("retired_op%02h", op), 32'(retired_cnt), 32'(model_cnt));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] ops [8];
        logic [5:0] op;
        ops = '{T_R, T_BEQ, T_BNE, T_LW, T_SW, T_ADDI, T_LUI, T_J};

        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            opcode = 6'($urandom); mem_ready = 1'($urandom); zero = 1'($urandom);
            @(negedge clk);
            chk("reset_outputs", 32'(obs), 32'h0);
            @(posedge clk); #1;
        end
        chk("reset_cnt", 32'(retired_cnt), 32'h0);
        rst_n = 1'b1;

        run_instr(T_LW,   1'b0, 0, 0, -1);
        run_instr(T_SW,   1'b0, 0, 3, -1);
        run_instr(T_BEQ,  1'b1, 0, 0, -1);
        run_instr(T_BNE,  1'b1, 0, 0, -1);
        run_instr(T_BEQ,  1'b0, 0, 0, -1);
        run_instr(T_BNE,  1'b0, 0, 0, -1);
        run_instr(T_R,    1'b0, 2, 0, -1);
        run_instr(T_ADDI, 1'b0, 0, 0, -1);
        run_instr(T_LUI,  1'b0, 0, 0, -1);
        run_instr(T_J,    1'b0, 0, 0, -1);
        run_instr(6'b111111, 1'b0, 0, 0, -1);
        run_instr(T_LW,   1'b0, 1, 2, 3);

        for (int i = 0; i < 16; i++) run_instr(T_J, 1'b0, 0, 0, -1);
        chk("wrap_cnt", 32'(retired_cnt), 32'h0);

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 7)];
            end
            run_instr(op, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 3), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
